lane_deskew_ctrl: RTL and testbench

- Multi-lane deskew and merge controller downstream of the per-lane byte-sync detectors in the MIPI receive path.
- Buffers each lane's aligned byte stream in a small FIFO and waits until every active lane has started.
- Then pops all lanes in lock-step, emitting one merged word per cycle.
- Detects excessive inter-lane skew and FIFO overflow, and sequences the end-of-burst flush.

---
 rtl/lane_deskew_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lane_deskew_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_deskew_ctrl.sv
// rtl/lane_deskew_ctrl.sv - multi-lane deskew FIFOs and lock-step merge controller
// Buffers up to four aligned byte lanes, waits for all active lanes, then pops them together.
module lane_deskew_ctrl #(
  parameter int SKEW_MAX   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  lane_cfg,
  input  logic [3:0]  lane_valid,
  input  logic [31:0] lane_dat,
  output logic        out_valid,
  output logic [31:0] out_dat,
  output logic        busy,
  output logic        frame_done,
  output logic        skew_err,
  output logic        ovf_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int ACW = (SKEW_MAX < 1) ? 1 : $clog2(SKEW_MAX + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, STREAM, END} state_t;

  state_t          state, state_nxt;
  logic [ACW-1:0]  align_cnt, align_cnt_nxt;
  logic [3:0]      mask, cfg_mask, wr_mask;
  logic [3:0]      want, push, pop_lane, nonempty, full, ovf_lane;
  logic            all_ready, pop, ovf, flush, load_mask, fd_nxt, se_nxt;
  logic [31:0]     head_word;

  logic [7:0]      mem [4][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr [4];
  logic [AW-1:0]   rd_ptr [4];
  logic [CW-1:0]   cnt [4];

  always_comb begin
    cfg_mask = 4'b0001;
    case (lane_cfg)
      2'd0: cfg_mask = 4'b0001;
      2'd1: cfg_mask = 4'b0011;
      2'd2: cfg_mask = 4'b0111;
      2'd3: cfg_mask = 4'b1111;
      default: cfg_mask = 4'b0001;
    endcase
  end

  // In IDLE the registered mask is stale; the first bytes of a burst use the live config.
  assign wr_mask = (state == IDLE) ? cfg_mask : mask;

  always_comb begin
    nonempty  = '0;
    full      = '0;
    head_word = '0;
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == CW'(FIFO_DEPTH));
      head_word[8*i +: 8] = mask[i] ? mem[i][rd_ptr[i]] : 8'h00;
    end
  end

  assign all_ready = &(nonempty | ~mask);
  assign pop       = all_ready && ((state == ALIGN) || (state == STREAM));
  assign pop_lane  = {4{pop}} & mask;
  assign want      = lane_valid & wr_mask & {4{state != END}};
  assign ovf_lane  = want & full & ~pop_lane;
  assign push      = want & ~ovf_lane;
  assign ovf       = |ovf_lane;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    align_cnt_nxt = align_cnt;
    load_mask     = 1'b0;
    fd_nxt        = 1'b0;
    se_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (|(lane_valid & cfg_mask)) begin
          state_nxt     = ALIGN;
          align_cnt_nxt = '0;
          load_mask     = 1'b1;
        end
      end
      ALIGN: begin
        if (all_ready) begin
          state_nxt = STREAM;
        end else if (align_cnt == ACW'(SKEW_MAX)) begin
          se_nxt    = 1'b1;
          state_nxt = END;
        end else begin
          align_cnt_nxt = align_cnt + ACW'(1);
        end
      end
      STREAM: begin
        if (!all_ready) begin
          fd_nxt    = 1'b1;
          state_nxt = END;
        end
      end
      END: begin
        if ((lane_valid & mask) == 4'b0000) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (ovf) state_nxt = END;
  end

  // Counts stay zero for the whole of END because writes are discarded there.
  assign flush = (state_nxt == END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      align_cnt  <= '0;
      mask       <= 4'b0001;
      out_valid  <= 1'b0;
      out_dat    <= '0;
      frame_done <= 1'b0;
      skew_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      align_cnt  <= align_cnt_nxt;
      if (load_mask) mask <= cfg_mask;
      out_valid  <= pop;
      if (pop) out_dat <= head_word;
      frame_done <= fd_nxt;
      skew_err   <= se_nxt;
      ovf_err    <= ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flush) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          cnt[i]    <= '0;
        end else begin
          if (push[i])     wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop_lane[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
          if (push[i] && !pop_lane[i])      cnt[i] <= cnt[i] + CW'(1);
          else if (!push[i] && pop_lane[i]) cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= lane_dat[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// tb/tb_lane_deskew_ctrl.sv - randomized burst bench for lane_deskew_ctrl
// Expected words come from per-lane start offsets and lengths, not from cycle-level state.
module tb_lane_deskew_ctrl;
  localparam int SKEW_MAX   = 4;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lane_cfg;
  logic [3:0]  lane_valid;
  logic [31:0] lane_dat;
  logic        out_valid;
  logic [31:0] out_dat;
  logic        busy, frame_done, skew_err, ovf_err;

  lane_deskew_ctrl #(.SKEW_MAX(SKEW_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .lane_cfg(lane_cfg), .lane_valid(lane_valid),
    .lane_dat(lane_dat), .out_valid(out_valid), .out_dat(out_dat), .busy(busy),
    .frame_done(frame_done), .skew_err(skew_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle
  logic        mon_en = 1'b0;
  int          n_fd, n_se, n_ovf;
  logic [31:0] got_dat [$];
  int          got_cyc [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        got_dat.push_back(out_dat);
        got_cyc.push_back(cyc);
      end
      if (frame_done) n_fd++;
      if (skew_err)   n_se++;
      if (ovf_err)    n_ovf++;
    end
  end

  // Burst description: per-lane start offset, length and bytes
  int         b_s   [4];
  int         b_len [4];
  logic [7:0] b_dat [4][32];

  task automatic run_burst(input logic [1:0] cfg, input bit garbage, output logic [31:0] first_w,
                           output logic [31:0] last_w);
    int smax, minlen, uend, start_cyc, nwords, k;
    bit skew;
    logic [31:0] exp_w;
    smax = 0; minlen = 1000; uend = 0;
    for (int i = 0; i <= int'(cfg); i++) begin
      if (b_s[i] > smax) smax = b_s[i];
      if (b_len[i] < minlen) minlen = b_len[i];
      if (b_s[i] + b_len[i] > uend) uend = b_s[i] + b_len[i];
    end
    skew   = (smax > SKEW_MAX);
    nwords = skew ? 0 : minlen;

    got_dat.delete(); got_cyc.delete();
    n_fd = 0; n_se = 0; n_ovf = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    lane_cfg  = cfg;
    start_cyc = cyc;
    for (int c = 0; c < uend; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (i <= int'(cfg)) begin
          lane_valid[i] = (c >= b_s[i]) && (c < b_s[i] + b_len[i]);
          lane_dat[8*i +: 8] = lane_valid[i] ? b_dat[i][c - b_s[i]] : 8'($urandom);
        end else begin
          lane_valid[i] = garbage ? 1'($urandom) : 1'b0;
          lane_dat[8*i +: 8] = 8'($urandom);
        end
      end
      if (garbage && c >= 1) lane_cfg = 2'($urandom);
      @(posedge clk); #1;
    end
    lane_valid = '0;
    lane_dat   = $urandom;

    k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_timeout", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;

    check("words", got_dat.size(), nwords);
    check("frame_done_cnt", n_fd, skew ? 0 : 1);
    check("skew_err_cnt", n_se, skew ? 1 : 0);
    check("ovf_err_cnt", n_ovf, 0);
    first_w = '0; last_w = '0;
    if (got_dat.size() > 0 && nwords > 0) begin
      check("first_latency", got_cyc[0] - start_cyc, smax + 2);
      first_w = got_dat[0];
      last_w  = got_dat[got_dat.size() - 1];
    end
    for (int w = 0; w < got_dat.size() && w < nwords; w++) begin
      exp_w = '0;
      for (int i = 0; i <= int'(cfg); i++) exp_w[8*i +: 8] = b_dat[i][w];
      check($sformatf("word%0d", w), got_dat[w], exp_w);
      check($sformatf("word%0d_cyc", w), got_cyc[w] - got_cyc[0], w);
    end
  endtask

  task automatic fill_lanes(input int len0, input int len1, input int len2, input int len3);
    b_len[0] = len0; b_len[1] = len1; b_len[2] = len2; b_len[3] = len3;
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 32; n++) b_dat[i][n] = 8'($urandom);
  endtask

  logic [31:0] fw, lw;

  initial begin
    reset = 1'b1; lane_cfg = '0; lane_valid = '0; lane_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_dat", out_dat, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {frame_done, skew_err, ovf_err}, 3'b000);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Four lanes aligned, incrementing bytes
    fill_lanes(16, 16, 16, 16);
    b_s = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 16; n++) b_dat[i][n] = 8'(8'h10 * i + n);
    run_burst(2'd3, 1'b0, fw, lw);
    check("t1_first", fw, 32'h30201000);
    check("t1_last", lw, 32'h3F2F1F0F);

    // Skew at the limit, then one beyond
    fill_lanes(8, 8, 8, 8);
    b_s = '{0, 4, 0, 0};
    run_burst(2'd1, 1'b0, fw, lw);
    fill_lanes(8, 8, 8, 8);
    b_s = '{0, 5, 0, 0};
    run_burst(2'd1, 1'b0, fw, lw);

    // Lane 2 ends early
    fill_lanes(16, 16, 14, 16);
    b_s = '{0, 0, 0, 0};
    run_burst(2'd3, 1'b0, fw, lw);

    // Single lane with garbage on the others and config churn
    fill_lanes(10, 10, 10, 10);
    b_s = '{0, 0, 0, 0};
    run_burst(2'd0, 1'b1, fw, lw);

    // Reset mid-stream
    @(posedge clk); #1;
    lane_cfg = 2'd3;
    for (int c = 0; c < 6; c++) begin
      lane_valid = 4'hF;
      lane_dat   = $urandom;
      @(posedge clk); #1;
    end
    check("pre_rst_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_dat", out_dat, 32'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pulses", {frame_done, skew_err, ovf_err}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;
    lane_valid = '0;
    repeat (2) @(posedge clk);
    fill_lanes(12, 12, 12, 12);
    b_s = '{0, 0, 0, 0};
    run_burst(2'd3, 1'b0, fw, lw);

    // Randomized bursts
    for (int t = 0; t < 25; t++) begin
      int mn;
      logic [1:0] cfg;
      cfg = 2'($urandom);
      fill_lanes($urandom_range(SKEW_MAX + 3, 16), $urandom_range(SKEW_MAX + 3, 16),
                 $urandom_range(SKEW_MAX + 3, 16), $urandom_range(SKEW_MAX + 3, 16));
      for (int i = 0; i < 4; i++)
        b_s[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, SKEW_MAX + 2)
                                              : $urandom_range(0, SKEW_MAX);
      mn = 100;
      for (int i = 0; i <= int'(cfg); i++) if (b_s[i] < mn) mn = b_s[i];
      for (int i = 0; i < 4; i++) b_s[i] = (b_s[i] >= mn) ? b_s[i] - mn : 0;
      run_burst(cfg, t[0], fw, lw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
